// File: rtl/game_pkg.sv
// game_pkg: state encoding, counter widths and timing defaults shared by the game sequencer
package game_pkg;
   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      PLAY        = 3'd1,
      DYING       = 3'd2,
      LEVEL_PAUSE = 3'd3,
      GAME_OVER   = 3'd4
   } state_t;
   localparam int LIVES_W = 3;
   localparam int LEVEL_W = 4;
   localparam int COUNT_W = 32;
   localparam logic [COUNT_W-1:0] COUNT_LIMIT = '1;
   localparam int unsigned DEATH_HOLD_DEF = 25000000;
   localparam int unsigned LEVEL_HOLD_DEF = 12500000;
   localparam int unsigned BLINK_TICKS_DEF = 3125000;
endpackage

// File: rtl/hold_timer.sv
// hold_timer: loadable down-counter that parks at zero and flags done there
module hold_timer
   import game_pkg::*;
(
   input  logic               i_Clk,
   input  logic               i_Rst_N,
   input  logic               load,
   input  logic [COUNT_W-1:0] load_val,
   output logic               done
);
   logic [COUNT_W-1:0] count;
   always_ff @(posedge i_Clk)
      if (!i_Rst_N) count <= '0;
      else if (load) count <= load_val;
      else if (count != '0) count <= count - COUNT_W'(1);
   assign done = count == '0;
endmodule

// File: rtl/game_state_controller.sv
// game_state_controller: game FSM with lives/level counters, death/level holds and frog blink
module game_state_controller
   import game_pkg::*;
#(
   parameter int unsigned LIVES_INI   = 3,
   parameter int unsigned MAX_LEVEL   = 9,
   parameter int unsigned DEATH_HOLD  = DEATH_HOLD_DEF,
   parameter int unsigned LEVEL_HOLD  = LEVEL_HOLD_DEF,
   parameter int unsigned BLINK_TICKS = BLINK_TICKS_DEF
)(
   input  logic               i_Clk,
   input  logic               i_Rst_N,
   input  logic               i_Start,
   input  logic               i_Has_Collided,
   input  logic               i_Level_Up,
   output logic               o_Game_Active,
   output logic               o_Draw_Frog,
   output logic               o_Game_Over,
   output logic [2:0]         o_State,
   output logic [LIVES_W-1:0] o_Lives,
   output logic [LEVEL_W-1:0] o_Level,
   output logic [LEVEL_W-1:0] o_Car_Speed
);
   state_t state, state_n;
   logic [LIVES_W-1:0] lives, lives_n;
   logic [LEVEL_W-1:0] level, level_n;
   logic [COUNT_W-1:0] load_val, blink_cnt;
   logic start_q, start_rise, load, done, blink_phase;

   assign start_rise = i_Start & ~start_q;

   hold_timer u_hold (
      .i_Clk    (i_Clk),
      .i_Rst_N  (i_Rst_N),
      .load     (load),
      .load_val (load_val),
      .done     (done)
   );

   always_comb begin
      state_n  = state;
      lives_n  = lives;
      level_n  = level;
      load     = 1'b0;
      load_val = COUNT_W'(DEATH_HOLD - 1);
      case (state)
         IDLE, GAME_OVER:
            if (start_rise) begin
               lives_n = LIVES_W'(LIVES_INI);
               level_n = LEVEL_W'(1);
               state_n = PLAY;
            end
         PLAY:
            if (i_Has_Collided) begin
               lives_n = (lives > LIVES_W'(1)) ? lives - LIVES_W'(1) : '0;
               state_n = (lives > LIVES_W'(1)) ? DYING : GAME_OVER;
               load    = lives > LIVES_W'(1);
            end else if (i_Level_Up) begin
               level_n  = (level >= LEVEL_W'(MAX_LEVEL)) ? LEVEL_W'(MAX_LEVEL) : level + LEVEL_W'(1);
               load     = 1'b1;
               load_val = COUNT_W'(LEVEL_HOLD - 1);
               state_n  = LEVEL_PAUSE;
            end
         DYING, LEVEL_PAUSE:
            if (done) state_n = PLAY;
         default: state_n = IDLE;
      endcase
   end

   // blink phase restarts at 0 on every DYING entry because it is held clear outside DYING
   always_ff @(posedge i_Clk)
      if (!i_Rst_N) begin
         state       <= IDLE;
         lives       <= '0;
         level       <= LEVEL_W'(1);
         start_q     <= 1'b0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else begin
         state   <= state_n;
         lives   <= lives_n;
         level   <= level_n;
         start_q <= i_Start;
         if (state != DYING) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
         end else if (blink_cnt == COUNT_W'(BLINK_TICKS - 1)) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else blink_cnt <= blink_cnt + COUNT_W'(1);
      end

   assign o_State       = state;
   assign o_Game_Active = state == PLAY;
   assign o_Game_Over   = state == GAME_OVER;
   assign o_Draw_Frog   = (state == DYING) ? blink_phase : (state == PLAY || state == LEVEL_PAUSE);
   assign o_Lives       = lives;
   assign o_Level       = level;
   assign o_Car_Speed   = level;
endmodule

// File: tb/tb_game_state_controller.sv
// tb_game_state_controller: scoreboard bench for the game sequencer with short hold/blink timings
module tb_game_state_controller;
   import game_pkg::*;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, coll = 1'b0, lvl = 1'b0;
   logic game_active, draw_frog, game_over;
   logic [2:0] st;
   logic [2:0] lives;
   logic [3:0] level, car_speed;
   logic [16:0] obs, exp_v;
   logic [16:0] sb[$];
   int checks = 0, passes = 0;

   always #5 clk = ~clk;

   game_state_controller #(
      .LIVES_INI(3), .MAX_LEVEL(9), .DEATH_HOLD(8), .LEVEL_HOLD(4), .BLINK_TICKS(2)
   ) dut (
      .i_Clk          (clk),
      .i_Rst_N        (rst_n),
      .i_Start        (start),
      .i_Has_Collided (coll),
      .i_Level_Up     (lvl),
      .o_Game_Active  (game_active),
      .o_Draw_Frog    (draw_frog),
      .o_Game_Over    (game_over),
      .o_State        (st),
      .o_Lives        (lives),
      .o_Level        (level),
      .o_Car_Speed    (car_speed)
   );

   assign obs = {st, lives, level, game_active, draw_frog, game_over, car_speed};

   // expected output vector: active/over/speed follow from state and level
   function automatic logic [16:0] e(input logic [2:0] s, input logic [2:0] lv, input logic [3:0] lev, input logic d);
      return {s, lv, lev, s == 3'd1, d, s == 3'd4, lev};
   endfunction

   // t = {rst_n, start, collision, level_up, expected outputs after the edge}
   task automatic tick(input logic [20:0] t);
      @(negedge clk);
      rst_n = t[20]; start = t[19]; coll = t[18]; lvl = t[17];
      sb.push_back(t[16:0]);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [20:0] tbl[$];
      tbl.push_back({4'b0000, e(0, 0, 1, 0)});
      tbl.push_back({4'b0100, e(0, 0, 1, 0)});
      tbl.push_back({4'b1000, e(0, 0, 1, 0)});
      tbl.push_back({4'b1010, e(0, 0, 1, 0)});
      foreach (tbl[i]) begin
         tick(tbl[i]);
         exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v) $display("FAIL reset[%0d] got %b want %b", i, obs, exp_v); else passes++;
      end
   endtask

   task automatic test_start;
      logic [20:0] tbl[$];
      tbl.push_back({4'b1100, e(1, 3, 1, 1)});
      for (int k = 0; k < 20; k++) tbl.push_back({4'b1100, e(1, 3, 1, 1)});
      tbl.push_back({4'b1000, e(1, 3, 1, 1)});
      foreach (tbl[i]) begin
         tick(tbl[i]);
         exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v) $display("FAIL start[%0d] got %b want %b", i, obs, exp_v); else passes++;
      end
   endtask

   task automatic test_dying;
      logic [20:0] tbl[$];
      tbl.push_back({4'b1010, e(2, 2, 1, 0)});
      for (int k = 1; k < 8; k++) tbl.push_back({4'b1111, e(2, 2, 1, k[1])});
      tbl.push_back({4'b1111, e(1, 2, 1, 1)});
      tbl.push_back({4'b1000, e(1, 2, 1, 1)});
      foreach (tbl[i]) begin
         tick(tbl[i]);
         exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v) $display("FAIL dying[%0d] got %b want %b", i, obs, exp_v); else passes++;
      end
   endtask

   task automatic test_game_over;
      logic [20:0] tbl[$];
      tbl.push_back({4'b1010, e(2, 1, 1, 0)});
      for (int k = 1; k < 8; k++) tbl.push_back({4'b1000, e(2, 1, 1, k[1])});
      tbl.push_back({4'b1000, e(1, 1, 1, 1)});
      tbl.push_back({4'b1010, e(4, 0, 1, 0)});
      tbl.push_back({4'b1011, e(4, 0, 1, 0)});
      tbl.push_back({4'b1100, e(1, 3, 1, 1)});
      tbl.push_back({4'b1000, e(1, 3, 1, 1)});
      foreach (tbl[i]) begin
         tick(tbl[i]);
         exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v) $display("FAIL game_over[%0d] got %b want %b", i, obs, exp_v); else passes++;
      end
   endtask

   task automatic test_level_up;
      logic [20:0] tbl[$];
      logic [3:0] lm = 4'd1;
      for (int n = 0; n < 10; n++) begin
         lm = (lm < 4'd9) ? lm + 4'd1 : 4'd9;
         tbl.push_back({4'b1001, e(3, 3, lm, 1)});
         for (int k = 0; k < 3; k++) tbl.push_back({4'b1001, e(3, 3, lm, 1)});
         tbl.push_back({4'b1001, e(1, 3, lm, 1)});
      end
      foreach (tbl[i]) begin
         tick(tbl[i]);
         exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v) $display("FAIL level_up[%0d] got %b want %b", i, obs, exp_v); else passes++;
      end
   endtask

   task automatic test_back_to_back;
      logic [20:0] tbl[$];
      tbl.push_back({4'b1011, e(2, 2, 9, 0)});
      tbl.push_back({4'b1000, e(2, 2, 9, 0)});
      tbl.push_back({4'b1000, e(2, 2, 9, 1)});
      tbl.push_back({4'b0000, e(0, 0, 1, 0)});
      tbl.push_back({4'b1000, e(0, 0, 1, 0)});
      tbl.push_back({4'b1100, e(1, 3, 1, 1)});
      tbl.push_back({4'b1010, e(2, 2, 1, 0)});
      for (int k = 1; k < 8; k++) tbl.push_back({4'b1000, e(2, 2, 1, k[1])});
      tbl.push_back({4'b1000, e(1, 2, 1, 1)});
      foreach (tbl[i]) begin
         tick(tbl[i]);
         exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v) $display("FAIL back_to_back[%0d] got %b want %b", i, obs, exp_v); else passes++;
      end
   endtask

   task automatic test_illegal_state;
      logic [20:0] tbl[$];
      @(negedge clk);
      force dut.state = state_t'(3'd6);
      #1;
      release dut.state;
      sb.push_back(e(0, 2, 1, 0));
      @(posedge clk);
      #1;
      exp_v = sb.pop_front(); checks++;
      if (obs !== exp_v) $display("FAIL illegal_recover got %b want %b", obs, exp_v); else passes++;
      tbl.push_back({4'b1100, e(1, 3, 1, 1)});
      tbl.push_back({4'b1000, e(1, 3, 1, 1)});
      foreach (tbl[i]) begin
         tick(tbl[i]);
         exp_v = sb.pop_front(); checks++;
         if (obs !== exp_v) $display("FAIL illegal_restart[%0d] got %b want %b", i, obs, exp_v); else passes++;
      end
   endtask

   initial begin
      test_reset();
      test_start();
      test_dying();
      test_game_over();
      test_level_up();
      test_back_to_back();
      test_illegal_state();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/game_state_controller.md
# game_state_controller

Top-level game sequencer for the Frogger-style design: owns the game state (idle, playing, dying, level pause, game over) and the lives and level counters, and drives the frog-movement block's game-active enable. Consumes the collision flag from the car/collision logic and the level-up pulse from frog movement. Publishes level, lives and a car-speed setting to the car and score-display blocks. It also gates frog drawing, including a blink pattern during the death pause.

## Interface
Parameters:
- LIVES_INI, 3 — lives at game start (1..7)
- MAX_LEVEL, 9 — level saturation value (1..15)
- DEATH_HOLD, 25000000 — cycles spent in DYING (1 s at 25 MHz)
- LEVEL_HOLD, 12500000 — cycles spent in LEVEL_PAUSE
- BLINK_TICKS, 3125000 — half-period of frog blink during DYING

Ports:
- i_Clk  in  1  pixel clock; single clock domain
- i_Rst_N  in  1  reset; synchronous and active-low
- i_Start  in  1  start button, already debounced; rising edge is the event
- i_Has_Collided  in  1  frog/car collision, level-sensitive
- i_Level_Up  in  1  one-cycle pulse when the frog reaches the top row
- o_Game_Active  out  1  enables frog movement
- o_Draw_Frog  out  1  frog sprite enable
- o_Game_Over  out  1  high in GAME_OVER
- o_State  out  3  current state encoding, for debug and the text overlay
- o_Lives  out  3  remaining lives
- o_Level  out  4  current level, 1..MAX_LEVEL
- o_Car_Speed  out  4  pixels per car tick; equals o_Level

## Operation
- States and encodings: IDLE=0, PLAY=1, DYING=2, LEVEL_PAUSE=3, GAME_OVER=4. Encodings 5..7 are illegal and recover to IDLE on the next clock.
- i_Start is rising-edge detected against a registered copy. The registered copy is cleared by reset.
- **IDLE**: on a start edge, load lives=LIVES_INI and level=1, then go to PLAY.
- **PLAY** with i_Has_Collided=1:
  - If lives==1: lives becomes 0 and the state goes to GAME_OVER.
  - Otherwise: decrement lives, load the hold counter with DEATH_HOLD-1, and go to DYING.
- **PLAY** with i_Level_Up=1 and no collision:
  - level = min(level+1, MAX_LEVEL).
  - Load the hold counter with LEVEL_HOLD-1 and go to LEVEL_PAUSE.
  - The pause happens even when the level is already saturated.
- **Simultaneous collision and level-up**: collision wins, and the level is unchanged.
- **DYING and LEVEL_PAUSE**: the hold counter decrements every cycle. The state returns to PLAY on the cycle the counter reads 0. Inputs, including i_Start, are ignored.
- **GAME_OVER**: a start edge reloads lives and level and goes directly to PLAY.
- **Inputs outside PLAY**: i_Has_Collided and i_Level_Up are ignored in every state except PLAY.
- **o_Draw_Frog**:
  - 1 in PLAY and LEVEL_PAUSE.
  - 0 in IDLE and GAME_OVER.
  - In DYING it toggles every BLINK_TICKS cycles, starting at 0 on DYING entry.
  - The blink counter is cleared on every DYING entry.
- **Derived outputs**: o_Game_Active=1 only in PLAY. o_Game_Over=1 only in GAME_OVER. o_Car_Speed=o_Level.
- **Counter ranges**: lives never underflows below 0. Level never exceeds MAX_LEVEL and never goes below 1 after the first start.

## Timing
- All outputs are registered and reflect the state register. An input sampled at edge N appears on the outputs after edge N.
- Reset values (while i_Rst_N=0 at an edge):
  - state=IDLE, lives=0, level=1
  - hold counter=0, blink counter=0
  - o_Game_Active=0, o_Draw_Frog=0, o_Game_Over=0, o_Car_Speed=1
- Reset asserted mid-DYING or mid-LEVEL_PAUSE aborts the hold immediately and gives the reset values above.
- DYING lasts exactly DEATH_HOLD cycles: the first cycle is at the entry edge and o_Game_Active returns to 1 on the following edge. LEVEL_PAUSE lasts exactly LEVEL_HOLD cycles in the same way.
- A collision still asserted on the first cycle back in PLAY is treated as a new collision. The frog block respawns the frog during the hold, so this is not expected in normal play.
- Hold and blink counters are 32 bits wide.

## Structure
- Package game_pkg holds:
  - the state enum/localparams (3 bits)
  - LIVES_W=3 and LEVEL_W=4
  - shared timing constants (COUNT_LIMIT and the hold defaults)
- One sub-module, hold_timer: a loadable 32-bit down-counter with a load input, a load value, and a done flag (count==0). It is instantiated once and shared by DYING and LEVEL_PAUSE.
- The blink counter, start edge detector and FSM live in the top module.

## Test plan
Bench parameters: DEATH_HOLD=8, LEVEL_HOLD=4, BLINK_TICKS=2.
- Reset, then a start pulse → PLAY one edge later with lives=3, level=1, o_Game_Active=1, o_Draw_Frog=1. Holding i_Start high for 20 cycles produces no further events.
- Collision in PLAY → DYING, lives=2, o_Game_Active=0. o_Draw_Frog reads 0,0,1,1,0,0,1,1 over the hold. PLAY resumes after exactly 8 cycles.
- Three collisions from the start → lives 2, then 1, then GAME_OVER with lives=0 and o_Game_Over=1. A later start edge gives PLAY with lives=3 and level=1.
- Level-up pulse in PLAY → LEVEL_PAUSE for 4 cycles, level=2, o_Car_Speed=2. Ten level-ups saturate the level at 9.
- Collision and level-up in the same cycle → DYING, level unchanged, lives decremented.
- i_Rst_N=0 in the middle of DYING → IDLE next edge with all outputs at reset values. Forcing the state to 6 → IDLE on the next edge.
